// File: rtl/xmem_resp.sv
// Memory-side responder for the Versat address generator: serialised
// single-port storage with programmable wait states and a pause handshake.
module xmem_resp #(
  parameter int MEM_ADDR_W = 10,
  parameter int DATA_W     = 32,
  parameter int WAIT_W     = 4,
  parameter int CNT_W      = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clr_i,
  input  logic [WAIT_W-1:0]     wait_i,
  input  logic                  mem_en_i,
  input  logic                  we_i,
  input  logic [MEM_ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0]     wdata_i,
  output logic                  pause_o,
  output logic [DATA_W-1:0]     rdata_o,
  output logic                  rvalid_o,
  output logic                  wack_o,
  output logic                  busy_o,
  output logic [CNT_W-1:0]      acc_cnt_o
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  state_t                  state_r, state_nxt_s;
  logic [WAIT_W-1:0]       cnt_r, cnt_nxt_s;
  logic [MEM_ADDR_W-1:0]   lat_addr_r;
  logic                    lat_we_r;
  logic [DATA_W-1:0]       lat_wdata_r;
  logic                    pause_r, rvalid_r, wack_r, busy_r;
  logic [DATA_W-1:0]       rdata_r;
  logic [CNT_W-1:0]        acc_cnt_r;
  logic                    accept_s, done_s;
  logic [MEM_ADDR_W-1:0]   acc_addr_s;
  logic                    acc_we_s;
  logic [DATA_W-1:0]       acc_wdata_s;

  logic [DATA_W-1:0] mem_r [2**MEM_ADDR_W];

  // Next-state logic; a zero-wait request completes straight from the inputs
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    accept_s    = 1'b0;
    done_s      = 1'b0;
    acc_addr_s  = lat_addr_r;
    acc_we_s    = lat_we_r;
    acc_wdata_s = lat_wdata_r;
    case (state_r)
      ST_IDLE: begin
        if (mem_en_i) begin
          accept_s = 1'b1;
          if (wait_i == {WAIT_W{1'b0}}) begin
            done_s      = 1'b1;
            acc_addr_s  = addr_i;
            acc_we_s    = we_i;
            acc_wdata_s = wdata_i;
          end else begin
            state_nxt_s = ST_WAIT;
            cnt_nxt_s   = wait_i;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_r == WAIT_W'(1)) begin
          done_s      = 1'b1;
          state_nxt_s = ST_IDLE;
          cnt_nxt_s   = {WAIT_W{1'b0}};
        end else begin
          cnt_nxt_s = cnt_r - WAIT_W'(1);
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = {WAIT_W{1'b0}};
      end
    endcase
  end

  // Control state, response strobes, read data and access counter
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r   <= ST_IDLE;
      cnt_r     <= {WAIT_W{1'b0}};
      pause_r   <= 1'b0;
      rvalid_r  <= 1'b0;
      wack_r    <= 1'b0;
      busy_r    <= 1'b0;
      rdata_r   <= {DATA_W{1'b0}};
      acc_cnt_r <= {CNT_W{1'b0}};
    end else begin
      state_r  <= state_nxt_s;
      cnt_r    <= cnt_nxt_s;
      pause_r  <= (state_nxt_s == ST_WAIT);
      rvalid_r <= done_s && !acc_we_s;
      wack_r   <= done_s && acc_we_s;
      busy_r   <= (state_nxt_s == ST_WAIT) || done_s;
      if (done_s && !acc_we_s) begin
        rdata_r <= mem_r[acc_addr_s];
      end
      // Clear takes priority over a coincident completion
      if (clr_i) begin
        acc_cnt_r <= {CNT_W{1'b0}};
      end else if (done_s && (acc_cnt_r != {CNT_W{1'b1}})) begin
        acc_cnt_r <= acc_cnt_r + CNT_W'(1);
      end
    end
  end

  // Request capture for accesses that sit in wait states
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lat_addr_r  <= {MEM_ADDR_W{1'b0}};
      lat_we_r    <= 1'b0;
      lat_wdata_r <= {DATA_W{1'b0}};
    end else if (accept_s) begin
      lat_addr_r  <= addr_i;
      lat_we_r    <= we_i;
      lat_wdata_r <= wdata_i;
    end
  end

  // Storage write; contents survive reset and an abandoned write never lands
  always_ff @(posedge clk_i) begin
    if (!rst_i && done_s && acc_we_s) begin
      mem_r[acc_addr_s] <= acc_wdata_s;
    end
  end

  assign pause_o   = pause_r;
  assign rdata_o   = rdata_r;
  assign rvalid_o  = rvalid_r;
  assign wack_o    = wack_r;
  assign busy_o    = busy_r;
  assign acc_cnt_o = acc_cnt_r;

endmodule

// File: tb/tb_xmem_resp.sv
// Directed self-checking bench for xmem_resp: wait states, pause handshake,
// mid-access reset, counter saturation and clear priority.
module tb_xmem_resp;

  logic        clk = 1'b0;
  logic        rst_i, clr_i, mem_en_i, we_i;
  logic [3:0]  wait_i;
  logic [9:0]  addr_i;
  logic [31:0] wdata_i;
  logic        pause_o, rvalid_o, wack_o, busy_o;
  logic [31:0] rdata_o;
  logic [15:0] acc_cnt_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  xmem_resp dut (
    .clk_i(clk), .rst_i(rst_i), .clr_i(clr_i), .wait_i(wait_i),
    .mem_en_i(mem_en_i), .we_i(we_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .pause_o(pause_o), .rdata_o(rdata_o), .rvalid_o(rvalid_o),
    .wack_o(wack_o), .busy_o(busy_o), .acc_cnt_o(acc_cnt_o)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance one cycle; inputs are driven and outputs sampled 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic we, input logic [9:0] a, input logic [31:0] d, input logic [3:0] w);
    mem_en_i = 1'b1; we_i = we; addr_i = a; wdata_i = d; wait_i = w;
  endtask

  initial begin
    int idx;
    rst_i = 1'b1; clr_i = 1'b0; mem_en_i = 1'b0; we_i = 1'b0;
    addr_i = 10'd0; wdata_i = 32'd0; wait_i = 4'd0;
    tick(); tick();
    rst_i = 1'b0;
    check_eq("rst_pause", 32'(pause_o), 32'd0);
    check_eq("rst_rvalid", 32'(rvalid_o), 32'd0);
    check_eq("rst_wack", 32'(wack_o), 32'd0);
    check_eq("rst_busy", 32'(busy_o), 32'd0);
    check_eq("rst_rdata", rdata_o, 32'd0);
    check_eq("rst_cnt", 32'(acc_cnt_o), 32'd0);

    // W=0: write then read addr 3
    req(1'b1, 10'd3, 32'hA5A5_0001, 4'd0);
    tick();
    mem_en_i = 1'b0;
    check_eq("w0_wack", 32'(wack_o), 32'd1);
    check_eq("w0_pause1", 32'(pause_o), 32'd0);
    check_eq("w0_busy", 32'(busy_o), 32'd1);
    tick();
    check_eq("w0_wack_drop", 32'(wack_o), 32'd0);
    req(1'b0, 10'd3, 32'd0, 4'd0);
    tick();
    mem_en_i = 1'b0;
    check_eq("w0_rvalid", 32'(rvalid_o), 32'd1);
    check_eq("w0_rdata", rdata_o, 32'hA5A5_0001);
    check_eq("w0_pause3", 32'(pause_o), 32'd0);
    check_eq("w0_cnt", 32'(acc_cnt_o), 32'd2);
    tick();

    // W=3 read of addr 3
    req(1'b0, 10'd3, 32'd0, 4'd3);
    tick();
    mem_en_i = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      check_eq("w3_pause", 32'(pause_o), 32'd1);
      check_eq("w3_rvalid_early", 32'(rvalid_o), 32'd0);
      check_eq("w3_busy", 32'(busy_o), 32'd1);
      tick();
    end
    check_eq("w3_rvalid", 32'(rvalid_o), 32'd1);
    check_eq("w3_pause_end", 32'(pause_o), 32'd0);
    check_eq("w3_rdata", rdata_o, 32'hA5A5_0001);
    check_eq("w3_cnt", 32'(acc_cnt_o), 32'd3);
    tick();
    check_eq("w3_rvalid_drop", 32'(rvalid_o), 32'd0);
    check_eq("w3_busy_drop", 32'(busy_o), 32'd0);

    // Preload addrs 0..3 back-to-back, then clear the counter
    for (int i = 0; i < 4; i++) begin
      req(1'b1, 10'(i), 32'(10 + i), 4'd0);
      tick();
      check_eq("pre_wack", 32'(wack_o), 32'd1);
    end
    mem_en_i = 1'b0;
    clr_i = 1'b1;
    tick();
    clr_i = 1'b0;
    check_eq("clr_cnt", 32'(acc_cnt_o), 32'd0);

    // W=2 generator-style stream; request held while paused
    idx = 0;
    for (int c = 0; c <= 13; c++) begin
      mem_en_i = (idx < 4); we_i = 1'b0; addr_i = 10'(idx); wait_i = 4'd2;
      if (c > 0) begin
        check_eq("gen_rvalid", 32'(rvalid_o), ((c % 3 == 0) && c <= 12) ? 32'd1 : 32'd0);
        check_eq("gen_pause", 32'(pause_o), ((c % 3 != 0) && c < 12) ? 32'd1 : 32'd0);
        if ((c % 3 == 0) && c <= 12) check_eq("gen_rdata", rdata_o, 32'(10 + c / 3 - 1));
      end
      if (mem_en_i && !pause_o) idx++;
      tick();
    end
    mem_en_i = 1'b0;
    check_eq("gen_cnt", 32'(acc_cnt_o), 32'd4);

    // W=5 access with wait_i changed mid-flight, then a W=0 follow-up
    req(1'b0, 10'd1, 32'd0, 4'd5);
    tick();
    mem_en_i = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      if (c == 2) wait_i = 4'd0;
      check_eq("w5_pause", 32'(pause_o), 32'd1);
      check_eq("w5_rvalid_early", 32'(rvalid_o), 32'd0);
      tick();
    end
    check_eq("w5_rvalid", 32'(rvalid_o), 32'd1);
    check_eq("w5_rdata", rdata_o, 32'd11);
    req(1'b0, 10'd2, 32'd0, 4'd0);
    tick();
    mem_en_i = 1'b0;
    check_eq("w5_next_rvalid", 32'(rvalid_o), 32'd1);
    check_eq("w5_next_pause", 32'(pause_o), 32'd0);
    check_eq("w5_next_rdata", rdata_o, 32'd12);
    tick();

    // Reset abandons an in-flight W=4 write
    req(1'b1, 10'd7, 32'h0000_0055, 4'd0);
    tick();
    mem_en_i = 1'b0;
    tick();
    req(1'b1, 10'd7, 32'hDEAD_BEEF, 4'd4);
    tick();
    mem_en_i = 1'b0;
    check_eq("rst_mid_pause1", 32'(pause_o), 32'd1);
    tick();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    check_eq("rst_mid_pause", 32'(pause_o), 32'd0);
    check_eq("rst_mid_cnt", 32'(acc_cnt_o), 32'd0);
    for (int c = 0; c < 4; c++) begin
      check_eq("rst_mid_wack", 32'(wack_o), 32'd0);
      tick();
    end
    req(1'b0, 10'd7, 32'd0, 4'd0);
    tick();
    mem_en_i = 1'b0;
    check_eq("rst_mid_rvalid", 32'(rvalid_o), 32'd1);
    check_eq("rst_mid_rdata", rdata_o, 32'h0000_0055);
    check_eq("rst_mid_cnt1", 32'(acc_cnt_o), 32'd1);
    tick();

    // Saturation and clear-vs-completion priority
    clr_i = 1'b1;
    tick();
    clr_i = 1'b0;
    for (int k = 0; k < 65535; k++) begin
      req(1'b0, 10'd0, 32'd0, 4'd0);
      tick();
    end
    check_eq("sat_reach", 32'(acc_cnt_o), 32'h0000_FFFF);
    tick();
    check_eq("sat_hold", 32'(acc_cnt_o), 32'h0000_FFFF);
    check_eq("sat_rvalid", 32'(rvalid_o), 32'd1);
    clr_i = 1'b1;
    tick();
    clr_i = 1'b0;
    mem_en_i = 1'b0;
    check_eq("clr_win_rvalid", 32'(rvalid_o), 32'd1);
    check_eq("clr_win_cnt", 32'(acc_cnt_o), 32'd0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
